// File: rtl/serial_frame_deserializer_if.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer_if
// Purpose : groups the serial input side and the parallel valid/ready output
//           side of serial_frame_deserializer into one bundle.
// Signals :
//   sin       serial data bit
//   sin_en    sin is consumed on this edge when high
//   sof       start of frame, qualifies sin as bit 0 of a new word
//   out_data  assembled word (WIDTH bits)
//   out_valid out_data holds an unconsumed word
//   out_ready consumer accepts out_data when out_valid is high
//   overrun   one-cycle pulse, completed word dropped (buffer full)
//   frame_err one-cycle pulse, sof arrived mid-frame
// Modports:
//   master  the stimulus/consumer side (drives sin, sin_en, sof, out_ready)
//   slave   the deserializer itself
// -----------------------------------------------------------------------------
interface serial_frame_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             sin_en;
  logic             sof;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;

  modport master (
    output sin, sin_en, sof, out_ready,
    input  out_data, out_valid, overrun, frame_err
  );

  modport slave (
    input  sin, sin_en, sof, out_ready,
    output out_data, out_valid, overrun, frame_err
  );
endinterface

// File: rtl/serial_frame_deserializer.sv
// -----------------------------------------------------------------------------
// serial_frame_deserializer
// Purpose : rebuilds WIDTH-bit words from the bit stream of a right-shift PISO.
//           A sof marker qualifies bit 0 of each word. Completed words go into
//           a one-entry output buffer with a valid/ready handshake. Overrun and
//           framing errors are reported as registered one-cycle pulses.
// Parameters:
//   WIDTH     word width, 2..32
//   LSB_FIRST 1: first received bit lands in out_data[0]
//             0: first received bit lands in out_data[WIDTH-1]
// Ports:
//   clk       rising-edge clock
//   areset_n  asynchronous active-low reset
//   bus       serial_frame_deserializer_if.slave (sin/sin_en/sof in,
//             out_data/out_valid/out_ready handshake, overrun/frame_err out)
// -----------------------------------------------------------------------------
module serial_frame_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                           clk,
  input  logic                           areset_n,
  serial_frame_deserializer_if.slave     bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           r_state,     w_state_next;
  logic [CW-1:0]    r_cnt,       w_cnt_next;
  logic [WIDTH-1:0] r_sr,        w_sr_next;
  logic [WIDTH-1:0] r_data,      w_data_next;
  logic             r_valid,     w_valid_next;
  logic             r_overrun,   w_overrun_next;
  logic             r_frame_err, w_frame_err_next;

  logic [WIDTH-1:0] w_sr_base;
  logic [WIDTH-1:0] w_sr_shifted;
  logic             w_accept;
  logic             w_complete;

  // A sof bit always begins a clean word, so the old contents (a finished
  // word or an abandoned partial one) are not carried into the shift.
  assign w_sr_base = bus.sof ? '0 : r_sr;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_sr_shifted = {bus.sin, w_sr_base[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_sr_shifted = {w_sr_base[WIDTH-2:0], bus.sin};
    end
  endgenerate

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_sr        <= w_sr_next;
      r_data      <= w_data_next;
      r_valid     <= w_valid_next;
      r_overrun   <= w_overrun_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_sr_next        = r_sr;
    w_data_next      = r_data;
    w_valid_next     = r_valid;
    w_overrun_next   = 1'b0;
    w_frame_err_next = 1'b0;
    w_accept         = 1'b0;
    w_complete       = 1'b0;

    // Consumer drains the buffer; a load below may refill it this same edge.
    if (r_valid && bus.out_ready) begin
      w_valid_next = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (bus.sin_en && bus.sof) begin
          w_accept     = 1'b1;
          w_cnt_next   = CW'(1);
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sin_en) begin
          w_accept = 1'b1;
          if (bus.sof) begin
            w_frame_err_next = 1'b1;
            w_cnt_next       = CW'(1);
          end else if (r_cnt == CW'(WIDTH - 1)) begin
            w_complete   = 1'b1;
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    if (w_accept) begin
      w_sr_next = w_sr_shifted;
    end

    // The buffer takes the freshly shifted value, which includes the last bit.
    if (w_complete) begin
      if (!r_valid || bus.out_ready) begin
        w_data_next  = w_sr_shifted;
        w_valid_next = 1'b1;
      end else begin
        w_overrun_next = 1'b1;
      end
    end
  end

  assign bus.out_data  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule
